sample_filter: RTL and testbench

SAMPLE_FILTER -- requirements
Module: sample_filter

---
 rtl/sample_filter_pkg.sv | 25 ++
 rtl/sf_fifo.sv | 61 ++++++
 rtl/sample_filter.sv | 140 ++++++++++++++
 tb/tb_sample_filter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_filter_pkg.sv
// Shared state encoding and helpers for the sample filter.
package sample_filter_pkg;

  localparam int unsigned MAX_CONS = 64;
  localparam int unsigned PC_W     = $clog2(MAX_CONS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Counts set bits among the low n bits of v; n is the caller's constraint count.
  function automatic logic [PC_W-1:0] popcount(input logic [MAX_CONS-1:0] v,
                                               input int unsigned        n);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < MAX_CONS; i++) begin
      if (i < n) cnt = cnt + PC_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sf_fifo.sv
// Power-of-two circular FIFO; head is read straight from storage so it holds while not popped.
module sf_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             empty_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  always_comb begin
    do_push     = push_i && !full_q;
    do_pop      = pop_i && !empty_q;
    wr_ptr_d    = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d       = cnt_q + CW'(do_push) - CW'(do_pop);
    empty_nxt_c = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CW'(DEPTH));
      empty_q  <= empty_nxt_c;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/sample_filter.sv
// Filters candidate samples against enabled constraint results and queues passing ones
// until a target number has been accepted.
module sample_filter
  import sample_filter_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 64,
  parameter int unsigned NUM_CONS = 20,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [CNT_W-1:0]                  target,
  input  logic                              mode,
  input  logic [$clog2(NUM_CONS+1)-1:0]     threshold,
  input  logic [NUM_CONS-1:0]               cons_en,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SAMPLE_W-1:0]               in_sample,
  input  logic [NUM_CONS-1:0]               in_cons,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SAMPLE_W-1:0]               out_sample,
  output logic [CNT_W-1:0]                  tried_cnt,
  output logic [CNT_W-1:0]                  accept_cnt,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned TH_W = $clog2(NUM_CONS + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic                mode_q, mode_d;
  logic [TH_W-1:0]     thr_q, thr_d;
  logic [NUM_CONS-1:0] en_q, en_d;
  logic [CNT_W-1:0]    tried_q, tried_d;
  logic [CNT_W-1:0]    accept_q, accept_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                fifo_full, fifo_empty, fifo_empty_nxt;
  logic                xfer, cons_ok, push, pop;

  // Handshake qualifiers and pass decision for the current candidate.
  always_comb begin
    xfer    = in_valid && in_ready;
    cons_ok = mode_q ? (popcount(MAX_CONS'(in_cons & en_q), NUM_CONS) >= PC_W'(thr_q))
                     : (&(in_cons | ~en_q));
    push    = xfer && cons_ok;
    pop     = out_valid && out_ready;
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode_q;
    thr_d    = thr_q;
    en_d     = en_q;
    tried_d  = tried_q;
    accept_d = accept_q;

    // Saturating counters; transfers only occur while running.
    if (xfer && (tried_q != '1))  tried_d  = tried_q + CNT_W'(1);
    if (push && (accept_q != '1)) accept_d = accept_q + CNT_W'(1);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          target_d = target;
          mode_d   = mode;
          thr_d    = threshold;
          en_d     = cons_en;
          tried_d  = '0;
          accept_d = '0;
          state_d  = (target == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (push && (accept_d == target_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty_nxt) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      mode_q   <= 1'b0;
      thr_q    <= '0;
      en_q     <= '0;
      tried_q  <= '0;
      accept_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      thr_q    <= thr_d;
      en_q     <= en_d;
      tried_q  <= tried_d;
      accept_q <= accept_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  sf_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .data_i      (in_sample),
    .data_o      (out_sample),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt)
  );

  // Both terms come from flops, so the inputs never reach these combinationally.
  assign in_ready   = (state_q == ST_RUN) && !fifo_full;
  assign out_valid  = !fifo_empty;
  assign tried_cnt  = tried_q;
  assign accept_cnt = accept_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sample_filter.sv
// Bench for sample_filter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_sample_filter;

  localparam int unsigned SW   = 64;
  localparam int unsigned NC   = 4;
  localparam int unsigned DP   = 4;
  localparam int unsigned CW   = 8;
  localparam int          CMAX = 255;

  logic          clk = 1'b0;
  logic          rst, start, mode, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [CW-1:0] target, tried_cnt, accept_cnt;
  logic [2:0]    threshold;
  logic [NC-1:0] cons_en, in_cons;
  logic [SW-1:0] in_sample, out_sample;

  always #5 clk = ~clk;

  sample_filter #(.SAMPLE_W(SW), .NUM_CONS(NC), .DEPTH(DP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .mode(mode),
    .threshold(threshold), .cons_en(cons_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .in_cons(in_cons), .out_valid(out_valid), .out_ready(out_ready),
    .out_sample(out_sample), .tried_cnt(tried_cnt), .accept_cnt(accept_cnt),
    .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 run, 2 drain, 3 done
  int            m_phase = 0, old_ph;
  logic [SW-1:0] m_q[$];
  logic [SW-1:0] m_dummy;
  int            m_tried = 0, m_acc = 0, m_target = 0, m_thr = 0;
  bit            m_mode = 0;
  logic [NC-1:0] m_en = '0;
  bit            m_in_ready = 0, m_out_valid = 0, live = 0;

  function automatic bit model_pass(input logic [NC-1:0] c);
    int n  = 0;
    bit ok = 1;
    for (int i = 0; i < NC; i++) begin
      if (m_en[i]) begin
        if (c[i]) n++;
        else ok = 0;
      end
    end
    return m_mode ? (n >= m_thr) : ok;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_q.delete(); m_tried = 0; m_acc = 0;
      m_target = 0; m_thr = 0; m_mode = 0; m_en = '0; live = 1;
    end else begin
      old_ph = m_phase;
      if (m_out_valid && out_ready) m_dummy = m_q.pop_front();
      if (in_valid && m_in_ready) begin
        if (m_tried < CMAX) m_tried++;
        if (model_pass(in_cons)) begin
          m_q.push_back(in_sample);
          if (m_acc < CMAX) m_acc++;
          if (m_acc == m_target) m_phase = 2;
        end
      end
      if ((old_ph == 0 || old_ph == 3) && start) begin
        m_target = int'(target); m_mode = mode; m_thr = int'(threshold); m_en = cons_en;
        m_tried = 0; m_acc = 0;
        m_phase = (target == 0) ? 2 : 1;
      end else if (old_ph == 2 && m_q.size() == 0) begin
        m_phase = 3;
      end
    end
    m_in_ready  = (m_phase == 1) && (m_q.size() < DP);
    m_out_valid = (m_q.size() > 0);
  end

  // ---------------- per-cycle compare ----------------
  logic [SW-1:0] got[$];
  logic [SW-1:0] want[$];

  always @(negedge clk) begin
    if (live) begin
      chk("in_ready",   64'(in_ready),   64'(m_in_ready));
      chk("out_valid",  64'(out_valid),  64'(m_out_valid));
      chk("busy",       64'(busy),       64'(m_phase == 1 || m_phase == 2));
      chk("done",       64'(done),       64'(m_phase == 3));
      chk("tried_cnt",  64'(tried_cnt),  64'(m_tried));
      chk("accept_cnt", 64'(accept_cnt), 64'(m_acc));
      if (m_out_valid) chk("out_sample", out_sample, m_q[0]);
      if (out_valid && out_ready) got.push_back(out_sample);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [SW-1:0] s_smp[$];
  logic [NC-1:0] s_cons[$];
  int            s_idx;

  task automatic clr_stream();
    s_smp.delete(); s_cons.delete(); s_idx = 0; got.delete(); want.delete();
  endtask

  task automatic pulse_start(input int t, input logic md, input int th, input logic [NC-1:0] en);
    start = 1'b1; target = CW'(t); mode = md; threshold = 3'(th); cons_en = en;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Presents stream items until index upto has been transferred or the budget runs out.
  task automatic feed(input int upto, input int budget);
    logic rdy;
    for (int c = 0; c < budget && s_idx < upto; c++) begin
      in_valid = 1'b1; in_sample = s_smp[s_idx]; in_cons = s_cons[s_idx];
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) s_idx++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("done_reached", 64'(done), 64'(1));
  endtask

  task automatic chk_got(input string nm);
    chk({nm, "_count"}, 64'(got.size()), 64'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      if (i < got.size()) chk({nm, "_data"}, got[i], want[i]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t, md, th, npop;
    logic [NC-1:0] en;
    rst = 1; start = 0; target = 0; mode = 0; threshold = 0; cons_en = 0;
    in_valid = 0; in_sample = 0; in_cons = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),   64'(0));
    chk("rst_out_valid", 64'(out_valid),  64'(0));
    chk("rst_busy",      64'(busy),       64'(0));
    chk("rst_done",      64'(done),       64'(0));
    chk("rst_tried",     64'(tried_cnt),  64'(0));
    chk("rst_accept",    64'(accept_cnt), 64'(0));
    @(posedge clk); #1;

    // mode 0, alternating all-pass / one-failing candidates
    clr_stream();
    for (int i = 0; i < 5; i++) begin
      s_smp.push_back(64'(100 + i));
      s_cons.push_back((i % 2 == 1) ? 4'b1110 : 4'b1111);
    end
    out_ready = 1;
    pulse_start(3, 1'b0, 0, 4'b1111);
    feed(5, 30);
    wait_done(30);
    chk("a_tried",  64'(tried_cnt),  64'(5));
    chk("a_accept", 64'(accept_cnt), 64'(3));
    want = '{64'd100, 64'd102, 64'd104};
    chk_got("a_out");

    // threshold mode: first candidate has no enabled passing constraint
    clr_stream();
    s_smp  = '{64'd200, 64'd201, 64'd202};
    s_cons = '{4'b1000, 4'b0011, 4'b0101};
    pulse_start(2, 1'b1, 2, 4'b0111);
    feed(3, 30);
    wait_done(30);
    chk("b_tried",  64'(tried_cnt),  64'(3));
    chk("b_accept", 64'(accept_cnt), 64'(2));
    want = '{64'd201, 64'd202};
    chk_got("b_out");

    // back-pressure: FIFO fills at DEPTH, then drains one per cycle
    clr_stream();
    for (int i = 0; i < 10; i++) begin
      s_smp.push_back(64'(300 + i));
      s_cons.push_back(4'b1111);
      want.push_back(64'(300 + i));
    end
    out_ready = 0;
    pulse_start(10, 1'b0, 0, 4'b1111);
    feed(10, 12);
    @(negedge clk);
    chk("c_stall_tried",    64'(tried_cnt),  64'(4));
    chk("c_stall_in_ready", 64'(in_ready),   64'(0));
    chk("c_stall_valid",    64'(out_valid),  64'(1));
    chk("c_stall_head",     out_sample,      64'd300);
    @(posedge clk); #1;
    out_ready = 1;
    feed(10, 60);
    wait_done(40);
    chk("c_tried",  64'(tried_cnt),  64'(10));
    chk("c_accept", 64'(accept_cnt), 64'(10));
    chk_got("c_out");

    // zero target skips the run
    pulse_start(0, 1'b0, 0, 4'b1111);
    @(posedge clk); #1;
    chk("d_done",     64'(done),       64'(1));
    chk("d_busy",     64'(busy),       64'(0));
    chk("d_tried",    64'(tried_cnt),  64'(0));
    chk("d_accept",   64'(accept_cnt), 64'(0));
    chk("d_in_ready", 64'(in_ready),   64'(0));

    // reset mid-run with entries queued, start on the same cycle
    clr_stream();
    s_smp  = '{64'd400, 64'd401, 64'd402};
    s_cons = '{4'b0000, 4'b0000, 4'b0000};
    out_ready = 0;
    pulse_start(10, 1'b0, 0, 4'b0000);
    feed(3, 10);
    @(negedge clk);
    chk("e_pre_tried", 64'(tried_cnt), 64'(3));
    @(posedge clk); #1;
    rst = 1; start = 1; target = 5;
    @(posedge clk); #1;
    rst = 0; start = 0;
    chk("e_out_valid", 64'(out_valid),  64'(0));
    chk("e_busy",      64'(busy),       64'(0));
    chk("e_done",      64'(done),       64'(0));
    chk("e_tried",     64'(tried_cnt),  64'(0));
    chk("e_accept",    64'(accept_cnt), 64'(0));
    @(posedge clk); #1;
    chk("e_idle_busy", 64'(busy),       64'(0));
    out_ready = 1;

    // start during RUN is ignored
    clr_stream();
    s_smp  = '{64'd500, 64'd501, 64'd502};
    s_cons = '{4'b1111, 4'b1111, 4'b1111};
    want   = '{64'd500, 64'd501, 64'd502};
    pulse_start(3, 1'b0, 0, 4'b1111);
    feed(1, 10);
    pulse_start(1, 1'b0, 0, 4'b1111);
    feed(3, 20);
    wait_done(30);
    chk("f_accept", 64'(accept_cnt), 64'(3));
    chk("f_tried",  64'(tried_cnt),  64'(3));
    chk_got("f_out");

    // randomized runs with stray start pulses and random back-pressure
    for (int r = 0; r < 6; r++) begin
      t  = $urandom_range(1, 12);
      md = $urandom_range(0, 1);
      en = NC'($urandom);
      npop = 0;
      for (int i = 0; i < NC; i++) npop += int'(en[i]);
      th = $urandom_range(0, npop);
      pulse_start(t, md[0], th, en);
      for (int c = 0; c < 800 && !done; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_sample = {$urandom, $urandom};
        in_cons   = NC'($urandom | $urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 19) == 0);
        target    = CW'($urandom_range(0, 3));
        @(posedge clk); #1;
      end
      start = 0; in_valid = 0; out_ready = 1;
      wait_done(20);
      chk("rnd_accept", 64'(accept_cnt), 64'(t));
    end

    // tried counter saturates before the target is reached
    pulse_start(250, 1'b0, 0, 4'b0001);
    for (int c = 0; c < 3000 && !done; c++) begin
      in_valid  = 1;
      in_sample = {$urandom, $urandom};
      in_cons   = NC'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 0;
    wait_done(20);
    chk("sat_tried",  64'(tried_cnt),  64'(255));
    chk("sat_accept", 64'(accept_cnt), 64'(250));

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
